// File: rtl/chan_scan_mux.sv
// chan_scan_mux: N-channel W-bit mux with registered output
// and a round-robin auto-scan mode driven by a dwell counter.
module chan_scan_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] I,
  input  logic [SEL_W-1:0]          Sel,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          OUT,
  output logic [SEL_W-1:0]          CH,
  output logic                      valid,
  output logic                      tick,
  output logic                      sel_err
);

  localparam int CNT_W =
    (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [SEL_W:0] NCH =
    (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH =
    SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(DWELL - 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             sel_ok;
  logic             dwell_done;
  logic [SEL_W-1:0] ch_inc;

  assign sel_ok     = {1'b0, Sel} < NCH;
  assign dwell_done = cnt_q == LAST_CNT;
  assign ch_inc     = (ch_q == LAST_CH)
                    ? '0
                    : ch_q + SEL_W'(1);

  // Next channel, counter and status flags; hold when en=0
  always_comb begin
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    err_d   = err_q;
    tick_d  = 1'b0;
    if (en) begin
      valid_d = 1'b1;
      unique case (1'b1)
        mode: begin
          err_d = 1'b0;
          if (dwell_done) begin
            cnt_d  = '0;
            ch_d   = ch_inc;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        !mode: begin
          cnt_d = '0;
          if (sel_ok) begin
            ch_d  = Sel;
            err_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output data follows the channel chosen on the same edge
  always_comb begin
    out_d = out_q;
    if (en) begin
      out_d = '0;
      for (int k = 0; k < CHANNELS; k++) begin
        if (ch_d == SEL_W'(k)) begin
          out_d = I[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign OUT     = out_q;
  assign CH      = ch_q;
  assign valid   = valid_q;
  assign tick    = tick_q;
  assign sel_err = err_q;

endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: three chan_scan_mux variants vs a
// behavioural model under directed and random stimulus.
module tb_chan_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_bus;
  logic [1:0]  sel;
  logic        mode;
  logic        en;

  logic [7:0]  o [3];
  logic [1:0]  c [3];
  logic        v [3];
  logic        t [3];
  logic        e [3];

  int n_ch [3] = '{4, 3, 4};
  int n_dw [3] = '{4, 2, 1};

  int m_ch  [3];
  int m_cnt [3];
  int m_out [3];
  int m_v   [3];
  int m_t   [3];
  int m_e   [3];

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chan_scan_mux #(
    .WIDTH(8), .CHANNELS(4),
    .SEL_W(2), .DWELL(4)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .I(i_bus), .Sel(sel),
    .mode(mode), .en(en),
    .OUT(o[0]), .CH(c[0]),
    .valid(v[0]), .tick(t[0]),
    .sel_err(e[0])
  );

  chan_scan_mux #(
    .WIDTH(8), .CHANNELS(3),
    .SEL_W(2), .DWELL(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .I(i_bus[23:0]), .Sel(sel),
    .mode(mode), .en(en),
    .OUT(o[1]), .CH(c[1]),
    .valid(v[1]), .tick(t[1]),
    .sel_err(e[1])
  );

  chan_scan_mux #(
    .WIDTH(8), .CHANNELS(4),
    .SEL_W(2), .DWELL(1)
  ) u_c (
    .clk(clk), .rst_n(rst_n),
    .I(i_bus), .Sel(sel),
    .mode(mode), .en(en),
    .OUT(o[2]), .CH(c[2]),
    .valid(v[2]), .tick(t[2]),
    .sel_err(e[2])
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_ch[k]  = 0;
      m_cnt[k] = 0;
      m_out[k] = 0;
      m_v[k]   = 0;
      m_t[k]   = 0;
      m_e[k]   = 0;
    end
  endtask

  task automatic m_step();
    for (int k = 0; k < 3; k++) begin
      m_t[k] = 0;
      if (en) begin
        m_v[k] = 1;
        if (mode) begin
          m_e[k] = 0;
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] == n_dw[k]) begin
            m_cnt[k] = 0;
            m_ch[k]  = (m_ch[k] + 1) % n_ch[k];
            m_t[k]   = 1;
          end
        end else begin
          m_cnt[k] = 0;
          if (int'(sel) < n_ch[k]) begin
            m_ch[k] = int'(sel);
            m_e[k]  = 0;
          end else begin
            m_e[k] = 1;
          end
        end
        m_out[k] = (i_bus >> (8 * m_ch[k])) & 255;
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.out%0d", ph, k),
          32'(o[k]), m_out[k]);
      chk($sformatf("%s.ch%0d", ph, k),
          32'(c[k]), m_ch[k]);
      chk($sformatf("%s.valid%0d", ph, k),
          32'(v[k]), m_v[k]);
      chk($sformatf("%s.tick%0d", ph, k),
          32'(t[k]), m_t[k]);
      chk($sformatf("%s.err%0d", ph, k),
          32'(e[k]), m_e[k]);
    end
  endtask

  task automatic cyc(input string ph);
    @(posedge clk);
    m_step();
    #1;
    check_all(ph);
  endtask

  task automatic arst(input string ph);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check_all(ph);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    i_bus = 32'h44332211;
    sel   = 2'd0;
    mode  = 1'b0;
    en    = 1'b1;
    rst_n = 1'b0;
    m_reset();
    #3;
    check_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    sel = 2'd1;
    cyc("t1a");
    cyc("t1b");
    arst("t1rst");
    sel = 2'd2;
    cyc("t1sel");
    chk("t1.out", 32'(o[0]), 32'h33);
    chk("t1.ch",  32'(c[0]), 2);
    chk("t1.vld", 32'(v[0]), 1);

    sel = 2'd1;
    cyc("t2a");
    sel = 2'd3;
    cyc("t2b");
    chk("t2.err", 32'(e[1]), 1);
    chk("t2.ch",  32'(c[1]), 1);
    chk("t2.out", 32'(o[1]), 32'h22);
    sel = 2'd0;
    cyc("t2c");
    chk("t2.out0", 32'(o[1]), 32'h11);
    chk("t2.err0", 32'(e[1]), 0);

    arst("t3rst");
    mode = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      cyc("t3");
      if (n == 4) begin
        chk("t3.ch4",  32'(c[0]), 1);
        chk("t3.tk4",  32'(t[0]), 1);
      end
      if (n == 16) begin
        chk("t3.wrap", 32'(c[0]), 0);
        chk("t3.tkw",  32'(t[0]), 1);
      end
    end

    for (int n = 0; n < 24; n++) begin
      en = (n % 4 == 1 || n % 4 == 2)
         ? 1'b0 : 1'b1;
      cyc("t4");
      if (!en)
        chk("t4.tick_off", 32'(t[0]), 0);
    end
    en = 1'b1;

    mode = 1'b0;
    sel  = 2'd2;
    cyc("t5a");
    mode = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      cyc("t5b");
      if (n == 3)
        chk("t5.ch3", 32'(c[0]), 2);
    end
    chk("t5.ch", 32'(c[0]), 3);
    mode = 1'b0;
    sel  = 2'd1;
    cyc("t5c");
    chk("t5.back", 32'(c[0]), 1);
    chk("t5.notk", 32'(t[0]), 0);

    mode = 1'b1;
    repeat (6) cyc("t6a");
    arst("t6rst");
    repeat (8) cyc("t6b");

    for (int n = 0; n < 3000; n++) begin
      i_bus = $urandom;
      sel   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0)
        mode = ~mode;
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0)
        arst("rrst");
      cyc("rnd");
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
